// File: rtl/pe_array_pkg.sv
// Shared fixed-point definitions for the PE-array psum path: width derivation,
// saturation limits and the saturating adder used by every accumulator lane.
package pe_array_pkg;

   localparam int unsigned MAX_DATA_W = 32;

   typedef logic signed [MAX_DATA_W:0] wide_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush
   } acc_state_t;

   typedef struct packed {
      logic                  sat;
      logic [MAX_DATA_W-1:0] sum;
   } sat_res_t;

   function automatic int unsigned data_w(input int unsigned top_bits,
                                          input int unsigned bot_bits);
      return top_bits + bot_bits;
   endfunction

   function automatic wide_t sat_max(input int unsigned w);
      return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t sat_min(input int unsigned w);
      return -(wide_t'(1) <<< (w - 1));
   endfunction

   // Operands arrive sign-extended to MAX_DATA_W; the result is clamped to a w-bit range.
   function automatic sat_res_t sat_add(input logic signed [MAX_DATA_W-1:0] a,
                                        input logic signed [MAX_DATA_W-1:0] b,
                                        input int unsigned                  w);
      wide_t    s;
      wide_t    hi;
      wide_t    lo;
      sat_res_t res;
      s  = {a[MAX_DATA_W-1], a} + {b[MAX_DATA_W-1], b};
      hi = sat_max(w);
      lo = sat_min(w);
      if (s > hi) begin
         res.sat = 1'b1;
         res.sum = hi[MAX_DATA_W-1:0];
      end else if (s < lo) begin
         res.sat = 1'b1;
         res.sum = lo[MAX_DATA_W-1:0];
      end else begin
         res.sat = 1'b0;
         res.sum = s[MAX_DATA_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One psum lane: wrapping index counter, per-index partial-sum buffer, saturating adder
// and the registered final-result output.
module psum_acc_lane
   import pe_array_pkg::*;
#(
   parameter int unsigned G_DATA_W    = 16,
   parameter int unsigned G_OFMAP_LEN = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                run,
   input  logic                ch_first,
   input  logic                ch_last,
   input  logic                relu,
   input  logic                advance,
   input  logic                psum_vld,
   input  logic [G_DATA_W-1:0] psum,
   output logic                wrapped,
   output logic                sat,
   output logic                dropped,
   output logic                out_vld,
   output logic [G_DATA_W-1:0] out
);

   localparam int unsigned IDX_W = (G_OFMAP_LEN > 1) ? $clog2(G_OFMAP_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(G_OFMAP_LEN - 1);

   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                wrapped_q, wrapped_d;
   logic                out_vld_q;
   logic [G_DATA_W-1:0] out_q;
   logic [G_DATA_W-1:0] buf_q [G_OFMAP_LEN];
   logic                beat;
   logic                at_end;
   logic [G_DATA_W-1:0] sum;
   logic [G_DATA_W-1:0] res_d;
   sat_res_t            add_res;

   // A lane that already finished this channel drops beats until the channel advances.
   assign beat    = run & psum_vld & ~wrapped_q;
   assign dropped = run & psum_vld & wrapped_q;
   assign at_end  = (idx_q == LAST_IDX);
   assign wrapped = wrapped_q | (beat & at_end);
   assign out_vld = out_vld_q;
   assign out     = out_q;

   always_comb begin
      add_res   = sat_add(MAX_DATA_W'(signed'(buf_q[idx_q])), MAX_DATA_W'(signed'(psum)),
                          G_DATA_W);
      sum       = ch_first ? psum : add_res.sum[G_DATA_W-1:0];
      res_d     = (relu && sum[G_DATA_W-1]) ? '0 : sum;
      sat       = beat & ~ch_first & add_res.sat;
      idx_d     = idx_q;
      wrapped_d = wrapped_q;
      if (beat) begin
         idx_d = at_end ? '0 : idx_q + IDX_W'(1);
         if (at_end) begin
            wrapped_d = 1'b1;
         end
      end
      if (clear) begin
         idx_d = '0;
      end
      if (clear || advance) begin
         wrapped_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         wrapped_q <= 1'b0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
      end else begin
         idx_q     <= idx_d;
         wrapped_q <= wrapped_d;
         out_vld_q <= beat & ch_last;
         if (beat && ch_last) begin
            out_q <= res_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (beat && !ch_last) begin
         buf_q[idx_q] <= sum;
      end
   end

endmodule

// File: rtl/psum_accumulator.sv
// Multi-channel psum accumulator: job FSM and channel counter driving one
// psum_acc_lane per PE-array column.
module psum_accumulator
   import pe_array_pkg::*;
#(
   parameter int unsigned G_ARRAY_WIDTH  = 4,
   parameter int unsigned G_TOP_BITS     = 2,
   parameter int unsigned G_BOT_BITS     = 14,
   parameter int unsigned G_OFMAP_LEN    = 24,
   parameter int unsigned G_MAX_CHANNELS = 8,
   localparam int unsigned DATA_W = data_w(G_TOP_BITS, G_BOT_BITS),
   localparam int unsigned CH_W   = $clog2(G_MAX_CHANNELS + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  start_i,
   input  logic [CH_W-1:0]                       num_ch_i,
   input  logic                                  relu_en_i,
   input  logic [G_ARRAY_WIDTH-1:0]              psum_vld_i,
   input  logic [G_ARRAY_WIDTH-1:0][DATA_W-1:0]  psum_i,
   output logic [G_ARRAY_WIDTH-1:0]              out_vld_o,
   output logic [G_ARRAY_WIDTH-1:0][DATA_W-1:0]  out_o,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  sat_o,
   output logic                                  err_o
);

   acc_state_t             state_q;
   logic [CH_W-1:0]        ch_cnt_q;
   logic [CH_W-1:0]        num_ch_q;
   logic                   relu_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   sat_q;
   logic                   err_q;
   logic [G_ARRAY_WIDTH-1:0] lane_wrapped;
   logic [G_ARRAY_WIDTH-1:0] lane_sat;
   logic [G_ARRAY_WIDTH-1:0] lane_dropped;
   logic                   run;
   logic                   start_ok;
   logic                   start_bad;
   logic                   advance;
   logic                   ch_first;
   logic                   ch_last;

   assign run       = (state_q == StRun);
   assign start_ok  = (state_q == StIdle) & start_i & (num_ch_i != '0) &
                      (32'(num_ch_i) <= G_MAX_CHANNELS);
   assign start_bad = (state_q == StIdle) & start_i & ~start_ok;
   // The final beat of the slowest lane and the channel increment share a cycle.
   assign advance   = run & (&lane_wrapped);
   assign ch_first  = (ch_cnt_q == '0);
   assign ch_last   = (ch_cnt_q == num_ch_q - CH_W'(1));

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign sat_o  = sat_q;
   assign err_o  = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         ch_cnt_q <= '0;
         num_ch_q <= '0;
         relu_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sat_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q  <= StRun;
                  ch_cnt_q <= '0;
                  num_ch_q <= num_ch_i;
                  relu_q   <= relu_en_i;
                  busy_q   <= 1'b1;
                  sat_q    <= 1'b0;
                  err_q    <= 1'b0;
               end else if (start_bad) begin
                  err_q <= 1'b1;
               end
               if (|psum_vld_i) begin
                  err_q <= 1'b1;
               end
            end
            StRun: begin
               if (|lane_sat) begin
                  sat_q <= 1'b1;
               end
               if (|lane_dropped) begin
                  err_q <= 1'b1;
               end
               if (advance) begin
                  if (ch_last) begin
                     state_q <= StFlush;
                  end else begin
                     ch_cnt_q <= ch_cnt_q + CH_W'(1);
                  end
               end
            end
            StFlush: begin
               if (|psum_vld_i) begin
                  err_q <= 1'b1;
               end
               state_q  <= StIdle;
               ch_cnt_q <= '0;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   for (genvar l = 0; l < G_ARRAY_WIDTH; l++) begin : g_lane
      psum_acc_lane #(
         .G_DATA_W   (DATA_W),
         .G_OFMAP_LEN(G_OFMAP_LEN)
      ) u_lane (
         .clk     (clk_i),
         .rst_n   (rst_ni),
         .clear   (start_ok),
         .run     (run),
         .ch_first(ch_first),
         .ch_last (ch_last),
         .relu    (relu_q),
         .advance (advance),
         .psum_vld(psum_vld_i[l]),
         .psum    (psum_i[l]),
         .wrapped (lane_wrapped[l]),
         .sat     (lane_sat[l]),
         .dropped (lane_dropped[l]),
         .out_vld (out_vld_o[l]),
         .out     (out_o[l])
      );
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed scenarios plus randomized jobs
// checked against a plain-arithmetic accumulate/saturate/ReLU model.
module tb_psum_accumulator;

   localparam int AW    = 4;
   localparam int LEN   = 24;
   localparam int MAXCH = 8;
   localparam int DW    = 16;
   localparam int CHW   = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   start;
   logic [CHW-1:0]         num_ch;
   logic                   relu_en;
   logic [AW-1:0]          psum_vld;
   logic [AW-1:0][DW-1:0]  psum;
   logic [AW-1:0]          out_vld;
   logic [AW-1:0][DW-1:0]  out;
   logic                   busy;
   logic                   done;
   logic                   sat;
   logic                   err;

   always #5 clk = ~clk;

   psum_accumulator dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (start),
      .num_ch_i  (num_ch),
      .relu_en_i (relu_en),
      .psum_vld_i(psum_vld),
      .psum_i    (psum),
      .out_vld_o (out_vld),
      .out_o     (out),
      .busy_o    (busy),
      .done_o    (done),
      .sat_o     (sat),
      .err_o     (err)
   );

   int vectors     = 0;
   int miscompares = 0;

   int          stim[AW][MAXCH][LEN];
   int          exp_val[AW][LEN];
   bit          exp_sat;
   logic [DW-1:0] got_val[AW][LEN];
   int          got_cnt[AW];
   int          lat_bad, busy_bad, done_cnt, done_cyc, timed_out;

   // Reference: each output is the channel-ordered sum, clamped after every addition.
   function automatic void compute_model(input int nch, input bit relu);
      int acc;
      exp_sat = 1'b0;
      for (int l = 0; l < AW; l++) begin
         for (int i = 0; i < LEN; i++) begin
            acc = stim[l][0][i];
            for (int c = 1; c < nch; c++) begin
               acc = acc + stim[l][c][i];
               if (acc > 32767) begin
                  acc = 32767;
                  exp_sat = 1'b1;
               end else if (acc < -32768) begin
                  acc = -32768;
                  exp_sat = 1'b1;
               end
            end
            if (relu && acc < 0) acc = 0;
            exp_val[l][i] = acc;
         end
      end
   endfunction

   function automatic void fill_random(input int amp);
      for (int l = 0; l < AW; l++)
         for (int c = 0; c < MAXCH; c++)
            for (int i = 0; i < LEN; i++)
               stim[l][c][i] = int'($urandom_range(0, 2 * amp)) - amp;
   endfunction

   function automatic void fill_const(input int v);
      for (int l = 0; l < AW; l++)
         for (int c = 0; c < MAXCH; c++)
            for (int i = 0; i < LEN; i++)
               stim[l][c][i] = v;
   endfunction

   // Drives one job; a lane may start channel c only once every lane finished channel c-1.
   task automatic run_job(input int nch, input bit relu, input int skew, input int vld_pct,
                          input int stop_cyc);
      int sent[AW];
      int snap[AW];
      bit last_beat[AW];
      int cyc;
      int tail;
      int ch;
      bit ok;
      for (int l = 0; l < AW; l++) begin
         sent[l]    = 0;
         got_cnt[l] = 0;
         for (int i = 0; i < LEN; i++) got_val[l][i] = 'x;
      end
      lat_bad = 0; busy_bad = 0; done_cnt = 0; done_cyc = -1; timed_out = 0;
      @(posedge clk); #1;
      start = 1'b1; num_ch = CHW'(nch); relu_en = relu;
      @(posedge clk); #1;
      start = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      cyc = 0; tail = 0;
      while (1) begin
         snap = sent;
         for (int l = 0; l < AW; l++) begin
            ch = sent[l] / LEN;
            ok = (sent[l] < nch * LEN) && (cyc >= l * skew) &&
                 (int'($urandom_range(1, 100)) <= vld_pct);
            for (int m = 0; m < AW; m++) if (snap[m] < ch * LEN) ok = 1'b0;
            psum_vld[l]  = ok;
            last_beat[l] = ok && (ch == nch - 1);
            if (ok) begin
               psum[l] = DW'(stim[l][ch][sent[l] % LEN]);
               sent[l]++;
            end else begin
               psum[l] = DW'($urandom);
            end
         end
         @(posedge clk); #1;
         psum_vld = '0;
         for (int l = 0; l < AW; l++) begin
            if (out_vld[l] !== last_beat[l]) lat_bad++;
            if (out_vld[l] === 1'b1) begin
               if (got_cnt[l] < LEN) got_val[l][got_cnt[l]] = out[l];
               got_cnt[l]++;
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy !== 1'b0) busy_bad++;
         end else if (done_cnt == 0 && busy !== 1'b1) begin
            busy_bad++;
         end
         cyc++;
         if (stop_cyc > 0 && cyc >= stop_cyc) break;
         if (done_cnt > 0) tail++;
         if (tail >= 4) break;
         if (cyc > 3000) begin
            timed_out = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; num_ch = '0; relu_en = 1'b0; psum_vld = '0; psum = '0;
      #2 rst_n = 1'b0;
      #10;
      vectors++; if (out_vld !== '0) begin miscompares++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
      vectors++; if (out !== '0) begin miscompares++; $display("FAIL reset_out: got %h want 0", out); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b want 0", sat); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_passthrough();
      fill_random(32767);
      for (int i = 0; i < LEN; i++) stim[0][0][i] = 'h4000 + i;
      compute_model(1, 1'b0);
      run_job(1, 1'b0, 0, 100, 0);
      vectors++; if (timed_out != 0) begin miscompares++; $display("FAIL pass_timeout: got %0d want 0", timed_out); end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL pass_done_cnt: got %0d want 1", done_cnt); end
      vectors++; if (done_cyc != LEN) begin miscompares++; $display("FAIL pass_done_cyc: got %0d want %0d", done_cyc, LEN); end
      vectors++; if (lat_bad != 0) begin miscompares++; $display("FAIL pass_latency: got %0d bad cycles want 0", lat_bad); end
      vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL pass_busy: got %0d bad cycles want 0", busy_bad); end
      for (int l = 0; l < AW; l++) begin
         vectors++;
         if (got_cnt[l] != LEN) begin miscompares++; $display("FAIL pass_cnt[%0d]: got %0d want %0d", l, got_cnt[l], LEN); end
         for (int i = 0; i < LEN; i++) begin
            vectors++;
            if (got_val[l][i] !== DW'(exp_val[l][i])) begin
               miscompares++;
               $display("FAIL pass_val[%0d][%0d]: got %h want %h", l, i, got_val[l][i], DW'(exp_val[l][i]));
            end
         end
      end
      vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL pass_sat: got %b want 0", sat); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL pass_err: got %b want 0", err); end
   endtask

   task automatic test_three_ch();
      int total;
      fill_const('h1000);
      run_job(3, 1'b0, 0, 100, 0);
      total = 0;
      for (int l = 0; l < AW; l++) begin
         total += got_cnt[l];
         for (int i = 0; i < LEN; i++) begin
            vectors++;
            if (got_val[l][i] !== 16'h3000) begin
               miscompares++;
               $display("FAIL three_val[%0d][%0d]: got %h want 3000", l, i, got_val[l][i]);
            end
         end
      end
      vectors++; if (total != AW * LEN) begin miscompares++; $display("FAIL three_total: got %0d want %0d", total, AW * LEN); end
      vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL three_sat: got %b want 0", sat); end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL three_done_cnt: got %0d want 1", done_cnt); end
      vectors++; if (lat_bad != 0) begin miscompares++; $display("FAIL three_latency: got %0d want 0", lat_bad); end
   endtask

   task automatic test_saturation();
      logic [DW-1:0] want;
      for (int k = 0; k < 3; k++) begin
         fill_const(k == 0 ? 'h6000 : -'h6000);
         want = (k == 0) ? 16'h7FFF : (k == 1) ? 16'h8000 : 16'h0000;
         run_job(2, k == 2, 0, 100, 0);
         for (int l = 0; l < AW; l++)
            for (int i = 0; i < LEN; i++) begin
               vectors++;
               if (got_val[l][i] !== want) begin
                  miscompares++;
                  $display("FAIL sat%0d_val[%0d][%0d]: got %h want %h", k, l, i, got_val[l][i], want);
               end
            end
         vectors++; if (sat !== 1'b1) begin miscompares++; $display("FAIL sat%0d_flag: got %b want 1", k, sat); end
         vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL sat%0d_done_cnt: got %0d want 1", k, done_cnt); end
      end
   endtask

   task automatic test_idle_errors();
      int bad_nch[2];
      bad_nch[0] = 0;
      bad_nch[1] = MAXCH + 1;
      for (int b = 0; b < 2; b++) begin
         fill_random(32767);
         run_job(1, 1'b0, 0, 100, 0);
         vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL badch%0d_pre_err: got %b want 0", b, err); end
         @(posedge clk); #1;
         start = 1'b1; num_ch = CHW'(bad_nch[b]);
         @(posedge clk); #1;
         start = 1'b0;
         vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL badch%0d_err: got %b want 1", b, err); end
         vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL badch%0d_busy: got %b want 0", b, busy); end
         repeat (3) @(posedge clk); #1;
         vectors++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL badch%0d_idle: got busy %b done %b want 0 0", b, busy, done);
         end
      end
      fill_random(32767);
      run_job(1, 1'b0, 0, 100, 0);
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL idlevld_pre_err: got %b want 0", err); end
      for (int k = 0; k < 3; k++) begin
         psum_vld = '1;
         for (int l = 0; l < AW; l++) psum[l] = DW'($urandom);
         @(posedge clk); #1;
         psum_vld = '0;
         vectors++; if (out_vld !== '0) begin miscompares++; $display("FAIL idlevld_out_vld%0d: got %b want 0", k, out_vld); end
      end
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL idlevld_err: got %b want 1", err); end
   endtask

   task automatic test_skewed();
      fill_random(20000);
      compute_model(2, 1'b0);
      run_job(2, 1'b0, 1, 100, 0);
      for (int l = 0; l < AW; l++)
         for (int i = 0; i < LEN; i++) begin
            vectors++;
            if (got_val[l][i] !== DW'(exp_val[l][i])) begin
               miscompares++;
               $display("FAIL skew_val[%0d][%0d]: got %h want %h", l, i, got_val[l][i], DW'(exp_val[l][i]));
            end
         end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL skew_done_cnt: got %0d want 1", done_cnt); end
      vectors++; if (lat_bad != 0) begin miscompares++; $display("FAIL skew_latency: got %0d want 0", lat_bad); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL skew_err: got %b want 0", err); end
      vectors++; if (sat !== exp_sat) begin miscompares++; $display("FAIL skew_sat: got %b want %b", sat, exp_sat); end
   endtask

   task automatic test_mid_reset();
      int late_done;
      fill_random(32767);
      run_job(2, 1'b0, 0, 100, 36);
      vectors++; if (got_cnt[0] != 12) begin miscompares++; $display("FAIL mrst_partial: got %0d want 12", got_cnt[0]); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (out_vld !== '0) begin miscompares++; $display("FAIL mrst_out_vld: got %b want 0", out_vld); end
      vectors++; if (out !== '0) begin miscompares++; $display("FAIL mrst_out: got %h want 0", out); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mrst_busy: got %b want 0", busy); end
      #2 rst_n = 1'b1;
      late_done = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done === 1'b1) late_done++;
      end
      vectors++; if (late_done != 0) begin miscompares++; $display("FAIL mrst_no_done: got %0d pulses want 0", late_done); end
      fill_random(12000);
      compute_model(3, 1'b1);
      run_job(3, 1'b1, 0, 80, 0);
      for (int l = 0; l < AW; l++)
         for (int i = 0; i < LEN; i++) begin
            vectors++;
            if (got_val[l][i] !== DW'(exp_val[l][i])) begin
               miscompares++;
               $display("FAIL mrst_val[%0d][%0d]: got %h want %h", l, i, got_val[l][i], DW'(exp_val[l][i]));
            end
         end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL mrst_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_random();
      int nch, skew, pct, amp;
      bit relu;
      for (int j = 0; j < 8; j++) begin
         nch  = int'($urandom_range(1, MAXCH));
         relu = 1'($urandom_range(0, 1));
         skew = int'($urandom_range(0, 2));
         pct  = int'($urandom_range(40, 100));
         amp  = (j % 3 == 0) ? 32767 : (j % 3 == 1) ? 8191 : 2047;
         fill_random(amp);
         compute_model(nch, relu);
         run_job(nch, relu, skew, pct, 0);
         for (int l = 0; l < AW; l++)
            for (int i = 0; i < LEN; i++) begin
               vectors++;
               if (got_val[l][i] !== DW'(exp_val[l][i])) begin
                  miscompares++;
                  $display("FAIL rnd%0d_val[%0d][%0d]: got %h want %h", j, l, i, got_val[l][i], DW'(exp_val[l][i]));
               end
            end
         vectors++; if (sat !== exp_sat) begin miscompares++; $display("FAIL rnd%0d_sat: got %b want %b", j, sat, exp_sat); end
         vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_err: got %b want 0", j, err); end
         vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL rnd%0d_done_cnt: got %0d want 1", j, done_cnt); end
         vectors++; if (timed_out != 0) begin miscompares++; $display("FAIL rnd%0d_timeout: got %0d want 0", j, timed_out); end
         vectors++; if (lat_bad != 0) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d want 0", j, lat_bad); end
         vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL rnd%0d_busy: got %0d want 0", j, busy_bad); end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_three_ch();
      test_saturation();
      test_idle_errors();
      test_skewed();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter G_ARRAY_WIDTH, default 4, number of PE-array columns (psum lanes).
REQ-002 SHALL have parameter G_TOP_BITS, default 2, integer bits of signed fixed-point psum.
REQ-003 SHALL have parameter G_BOT_BITS, default 14, fractional bits; DATA_W = G_TOP_BITS+G_BOT_BITS.
REQ-004 SHALL have parameter G_OFMAP_LEN, default 24, psums per lane per channel pass.
REQ-005 SHALL have parameter G_MAX_CHANNELS, default 8, maximum input channels accumulated; CH_W = clog2(G_MAX_CHANNELS+1).
REQ-006 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start_i  input  1  one-cycle job start pulse.
REQ-009 SHALL have port num_ch_i  input  CH_W  channels in job, sampled on accepted start.
REQ-010 SHALL have port relu_en_i  input  1  clamp negative results to 0, sampled on accepted start.
REQ-011 SHALL have port psum_vld_i  input  G_ARRAY_WIDTH  per-lane psum valid from array bottom edge.
REQ-012 SHALL have port psum_i  input  G_ARRAY_WIDTH x DATA_W  per-lane signed psum.
REQ-013 SHALL have port out_vld_o  output  G_ARRAY_WIDTH  per-lane final result valid.
REQ-014 SHALL have port out_o  output  G_ARRAY_WIDTH x DATA_W  per-lane final result.
REQ-015 SHALL have port busy_o  output  1  high from accepted start until done.
REQ-016 SHALL have port done_o  output  1  one-cycle job completion pulse.
REQ-017 SHALL have port sat_o  output  1  sticky: saturation occurred in current/last job.
REQ-018 SHALL have port err_o  output  1  sticky: psum_vld_i seen while IDLE, or bad num_ch_i.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> FLUSH -> IDLE.
REQ-020 SHALL accept start_i only in IDLE; num_ch_i of 0 or >G_MAX_CHANNELS sets err_o, stays IDLE.
REQ-021 On accepted start SHALL clear channel counter, all lane index counters, sat_o, err_o; enter RUN.
REQ-022 In RUN, each lane SHALL keep an index 0..G_OFMAP_LEN-1, advancing by one per psum_vld_i beat, wrapping to 0.
REQ-023 Channel 0 beat SHALL write psum_i to buffer[lane][index]; later channels SHALL write saturating sum buffer+psum_i.
REQ-024 Saturation SHALL clamp to 0x7FFF / 0x8000 (DATA_W=16) and set sat_o.
REQ-025 On last channel beat SHALL not write buffer; SHALL drive out_o = saturated sum (ReLU applied if latched), out_vld_o high exactly one cycle later (latency 1).
REQ-026 Channel counter SHALL increment when every lane has wrapped in the current channel; lanes finishing early SHALL ignore further beats until increment (beats dropped, err_o set).
REQ-027 After last channel completes SHALL enter FLUSH for one cycle (final out_vld_o), then pulse done_o and return to IDLE.
REQ-028 Beat and channel increment in same cycle SHALL both take effect; beat counts toward the old channel.
REQ-029 psum_vld_i in IDLE or FLUSH SHALL be dropped and set err_o.
REQ-030 num_ch_i=1 SHALL pass psums through (plus ReLU) without buffer writes.

Reset
REQ-031 rst_ni low SHALL asynchronously force IDLE, all counters 0, out_vld_o 0, out_o 0, busy_o 0, done_o 0, sat_o 0, err_o 0.
REQ-032 Buffer contents SHALL not require reset; reset mid-job SHALL abandon the job with no done_o.

Structure
REQ-033 Package pe_array_pkg SHALL hold DATA_W derivation, fixed-point saturation limits, and the saturating-add function.
REQ-034 Per-lane index counter, buffer, adder and output register SHALL be sub-module psum_acc_lane, instantiated G_ARRAY_WIDTH times; FSM and channel counter in top.

Verification
REQ-035 num_ch=1, relu off, lane0 psums 0x4000..: out_o equals input, out_vld_o 1 cycle later, done_o after 24 beats.
REQ-036 num_ch=3, all lanes constant 0x1000: every out_o = 0x3000, 96 total results, sat_o 0.
REQ-037 num_ch=2, psums 0x6000 twice: out_o = 0x7FFF, sat_o 1; with -0x6000: 0x8000, or 0x0000 with relu on.
REQ-038 psum_vld_i asserted while IDLE: no out_vld_o, err_o 1; start with num_ch=0: stays IDLE, err_o 1.
REQ-039 Lanes skewed by 1 cycle each (diagonal arrival), num_ch=2: results correct per lane, single done_o.
REQ-040 rst_ni low mid channel 1: outputs 0 immediately, no done_o; new start runs clean job correctly.
